// File: rtl/kmeans_pkg.sv
// Shared player-count constants, coordinate widths and FSM state encoding.
// Constants only; no latency or backpressure of its own.
package kmeans_pkg;

    localparam int X_W       = 11;
    localparam int Y_W       = 10;
    localparam int REJ_W     = 3;
    localparam int NUM_SLOTS = 4;

    localparam logic [1:0] ONE_PLAYER   = 2'd0;
    localparam logic [1:0] TWO_PLAYERS  = 2'd1;
    localparam logic [1:0] THREE_PLAYERS = 2'd2;
    localparam logic [1:0] FOUR_PLAYERS = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/ema_step.sv
// Per-player combinational step: first-sample load, EMA, optional jump reject
// (CENTROID_SMOOTHER_JUMP_REJECT_EN). Zero latency; no flow control.
module ema_step
    import kmeans_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2
`ifdef CENTROID_SMOOTHER_JUMP_REJECT_EN
    ,
    parameter int MAX_JUMP     = 200,
    parameter int REJECT_LIMIT = 3
`endif
) (
    input  logic [X_W-1:0]   old_x,
    input  logic [Y_W-1:0]   old_y,
    input  logic [X_W-1:0]   raw_x,
    input  logic [Y_W-1:0]   raw_y,
    input  logic             init,
`ifdef CENTROID_SMOOTHER_JUMP_REJECT_EN
    input  logic [REJ_W-1:0] rej_cnt,
    output logic [REJ_W-1:0] rej_cnt_nxt,
`endif
    output logic [X_W-1:0]   new_x,
    output logic [Y_W-1:0]   new_y
);

    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic [X_W-1:0]     ema_x;
    logic [Y_W-1:0]     ema_y;

    assign dx = $signed({1'b0, raw_x}) - $signed({1'b0, old_x});
    assign dy = $signed({2'b00, raw_y}) - $signed({2'b00, old_y});

    // Floor shift keeps the result between old and raw, so truncation is safe.
    assign ema_x = X_W'({1'b0, old_x} + 12'(dx >>> ALPHA_SHIFT));
    assign ema_y = Y_W'({2'b00, old_y} + 12'(dy >>> ALPHA_SHIFT));

`ifdef CENTROID_SMOOTHER_JUMP_REJECT_EN
    logic [11:0] abs_dx;
    logic [11:0] abs_dy;
    logic        jump;

    assign abs_dx = dx[11] ? 12'(-dx) : 12'(dx);
    assign abs_dy = dy[11] ? 12'(-dy) : 12'(dy);
    assign jump   = (abs_dx + abs_dy) > 12'(MAX_JUMP);

    always_comb begin
        new_x       = raw_x;
        new_y       = raw_y;
        rej_cnt_nxt = '0;
        if (init) begin
            if (!jump) begin
                new_x = ema_x;
                new_y = ema_y;
            end else if (rej_cnt != REJ_W'(REJECT_LIMIT - 1)) begin
                new_x       = old_x;
                new_y       = old_y;
                rej_cnt_nxt = rej_cnt + REJ_W'(1);
            end
        end
    end
`else
    always_comb begin
        new_x = raw_x;
        new_y = raw_y;
        if (init) begin
            new_x = ema_x;
            new_y = ema_y;
        end
    end
`endif

endmodule

// File: rtl/centroid_smoother.sv
// Temporal EMA smoother for up to four player centroids; optional jump reject via CENTROID_SMOOTHER_JUMP_REJECT_EN.
// Latency: valid_out N+2 cycles after valid_in (one player per cycle).
// Backpressure: none; valid_in arriving while busy_out is high is dropped.
module centroid_smoother
    import kmeans_pkg::*;
#(
    parameter int ALPHA_SHIFT  = 2,
    parameter int MAX_JUMP     = 200,
    parameter int REJECT_LIMIT = 3
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic [X_W-1:0] x_in [NUM_SLOTS-1:0],
    input  logic [Y_W-1:0] y_in [NUM_SLOTS-1:0],
    input  logic           valid_in,
    input  logic [1:0]     num_players,
    output logic [X_W-1:0] x_out [NUM_SLOTS-1:0],
    output logic [Y_W-1:0] y_out [NUM_SLOTS-1:0],
    output logic           valid_out,
    output logic           busy_out
);

    if (ALPHA_SHIFT < 0 || ALPHA_SHIFT > 4 || MAX_JUMP < 0 || MAX_JUMP > 2047 ||
        REJECT_LIMIT < 1 || REJECT_LIMIT > 7) begin : g_bad_cfg
        $error("centroid_smoother: parameter out of legal range");
    end

    state_t               state;
    logic [1:0]           idx;
    logic [1:0]           n_lat;
    logic [X_W-1:0]       x_snap [NUM_SLOTS-1:0];
    logic [Y_W-1:0]       y_snap [NUM_SLOTS-1:0];
    logic [NUM_SLOTS-1:0] init_flag;
    logic [X_W-1:0]       step_x;
    logic [Y_W-1:0]       step_y;
`ifdef CENTROID_SMOOTHER_JUMP_REJECT_EN
    logic [REJ_W-1:0]     rej_cnt [NUM_SLOTS-1:0];
    logic [REJ_W-1:0]     step_cnt;
`endif

    ema_step #(
        .ALPHA_SHIFT (ALPHA_SHIFT)
`ifdef CENTROID_SMOOTHER_JUMP_REJECT_EN
        ,
        .MAX_JUMP    (MAX_JUMP),
        .REJECT_LIMIT(REJECT_LIMIT)
`endif
    ) u_step (
        .old_x      (x_out[idx]),
        .old_y      (y_out[idx]),
        .raw_x      (x_snap[idx]),
        .raw_y      (y_snap[idx]),
        .init       (init_flag[idx]),
`ifdef CENTROID_SMOOTHER_JUMP_REJECT_EN
        .rej_cnt    (rej_cnt[idx]),
        .rej_cnt_nxt(step_cnt),
`endif
        .new_x      (step_x),
        .new_y      (step_y)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            idx       <= '0;
            n_lat     <= '0;
            init_flag <= '0;
            valid_out <= 1'b0;
            busy_out  <= 1'b0;
            for (int p = 0; p < NUM_SLOTS; p++) begin
                x_out[p]  <= '0;
                y_out[p]  <= '0;
                x_snap[p] <= '0;
                y_snap[p] <= '0;
`ifdef CENTROID_SMOOTHER_JUMP_REJECT_EN
                rej_cnt[p] <= '0;
`endif
            end
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        n_lat    <= num_players;
                        idx      <= '0;
                        state    <= UPDATE;
                        busy_out <= 1'b1;
                        for (int p = 0; p < NUM_SLOTS; p++) begin
                            x_snap[p] <= x_in[p];
                            y_snap[p] <= y_in[p];
                            // Absent players restart from a raw load when they return.
                            if (p > int'(num_players)) begin
                                init_flag[p] <= 1'b0;
`ifdef CENTROID_SMOOTHER_JUMP_REJECT_EN
                                rej_cnt[p]   <= '0;
`endif
                            end
                        end
                    end
                end
                UPDATE: begin
                    x_out[idx]     <= step_x;
                    y_out[idx]     <= step_y;
                    init_flag[idx] <= 1'b1;
`ifdef CENTROID_SMOOTHER_JUMP_REJECT_EN
                    rej_cnt[idx]   <= step_cnt;
`endif
                    if (idx == n_lat) begin
                        state     <= DONE;
                        valid_out <= 1'b1;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_smoother.sv
// Bench for centroid_smoother: directed scenarios plus random frames against a
// plain-arithmetic reference model of the smoothing rules.
module tb_centroid_smoother;

    localparam int A     = 2;
    localparam int MJ    = 200;
    localparam int LIMIT = 3;
`ifdef CENTROID_SMOOTHER_JUMP_REJECT_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] x_in [3:0];
    logic [9:0]  y_in [3:0];
    logic        valid_in;
    logic [1:0]  num_players;
    logic [10:0] x_out [3:0];
    logic [9:0]  y_out [3:0];
    logic        valid_out;
    logic        busy_out;

    int total = 0;
    int bad   = 0;

    int mx [4];
    int my [4];
    bit minit [4];
    int mcnt [4];

    always #5 clk_in = ~clk_in;

    centroid_smoother #(.ALPHA_SHIFT(A), .MAX_JUMP(MJ), .REJECT_LIMIT(LIMIT)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .x_in       (x_in),
        .y_in       (y_in),
        .valid_in   (valid_in),
        .num_players(num_players),
        .x_out      (x_out),
        .y_out      (y_out),
        .valid_out  (valid_out),
        .busy_out   (busy_out)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int floor_div(input int d, input int m);
        if (d >= 0) return d / m;
        return -((-d + m - 1) / m);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < 4; p++) begin
            mx[p] = 0; my[p] = 0; minit[p] = 0; mcnt[p] = 0;
        end
    endfunction

    function automatic void model_frame(input int n, input int rx [4], input int ry [4]);
        for (int p = 0; p < 4; p++) begin
            if (p > n) begin
                minit[p] = 0; mcnt[p] = 0;
            end else if (!minit[p]) begin
                mx[p] = rx[p]; my[p] = ry[p]; minit[p] = 1; mcnt[p] = 0;
            end else if (JUMP_EN && (iabs(rx[p] - mx[p]) + iabs(ry[p] - my[p]) > MJ)) begin
                mcnt[p]++;
                if (mcnt[p] == LIMIT) begin
                    mx[p] = rx[p]; my[p] = ry[p]; mcnt[p] = 0;
                end
            end else begin
                mx[p] = mx[p] + floor_div(rx[p] - mx[p], 1 << A);
                my[p] = my[p] + floor_div(ry[p] - my[p], 1 << A);
                mcnt[p] = 0;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("%s_x%0d", tag, p), int'(x_out[p]), mx[p]);
            check($sformatf("%s_y%0d", tag, p), int'(y_out[p]), my[p]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
    endtask

    // Drive one frame, measure valid_out latency and compare all outputs.
    task automatic run_frame(input string tag, input int n, input int rx [4], input int ry [4]);
        int lat;
        @(negedge clk_in);
        for (int p = 0; p < 4; p++) begin
            x_in[p] = 11'(rx[p]);
            y_in[p] = 10'(ry[p]);
        end
        num_players = 2'(n);
        valid_in    = 1'b1;
        model_frame(n, rx, ry);
        @(negedge clk_in);
        valid_in = 1'b0;
        for (int p = 0; p < 4; p++) begin
            x_in[p] = 11'($urandom);
            y_in[p] = 10'($urandom);
        end
        lat = 1;
        while (!valid_out && lat < 20) begin
            @(negedge clk_in);
            lat++;
        end
        check({tag, "_lat"}, lat, n + 2);
        check_outputs(tag);
    endtask

    int rx [4];
    int ry [4];
    int ex2, ey2;

    initial begin
        rst_in = 1'b1;
        valid_in = 1'b0;
        num_players = 2'd0;
        for (int p = 0; p < 4; p++) begin
            x_in[p] = '0;
            y_in[p] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        check("rst_valid", int'(valid_out), 0);
        check("rst_busy", int'(busy_out), 0);
        check_outputs("rst");

        // Init load then two EMA steps on player 0.
        rx = '{100, 0, 0, 0}; ry = '{50, 0, 0, 0};
        run_frame("init", 0, rx, ry);
        check("init_x0", int'(x_out[0]), 100);
        rx[0] = 200;
        run_frame("ema1", 0, rx, ry);
        check("ema1_x0", int'(x_out[0]), 125);
        rx[0] = 100;
        run_frame("ema2", 0, rx, ry);
        check("ema2_x0", int'(x_out[0]), 118);

        // Latency and blocking: a second valid_in while busy is dropped.
        rx = '{300, 400, 500, 600}; ry = '{10, 20, 30, 40};
        @(negedge clk_in);
        for (int p = 0; p < 4; p++) begin
            x_in[p] = 11'(rx[p]);
            y_in[p] = 10'(ry[p]);
        end
        num_players = 2'd3;
        valid_in = 1'b1;
        model_frame(3, rx, ry);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_in);
            valid_in = (k == 2);
            if (k == 2) begin
                for (int p = 0; p < 4; p++) x_in[p] = 11'd2000;
            end
            check($sformatf("blk_busy_c%0d", k), int'(busy_out), (k <= 5) ? 1 : 0);
            check($sformatf("blk_vld_c%0d", k), int'(valid_out), (k == 5) ? 1 : 0);
        end
        valid_in = 1'b0;
        check_outputs("blk");

        // Jump reject: two held samples, then a snap on the third.
        do_reset();
        rx = '{125, 0, 0, 0}; ry = '{50, 0, 0, 0};
        run_frame("jmp0", 0, rx, ry);
        rx[0] = 600;
        for (int f = 1; f <= 3; f++) begin
            run_frame($sformatf("jmp%0d", f), 0, rx, ry);
            if (JUMP_EN) check($sformatf("jmp%0d_hold", f), int'(x_out[0]), (f < 3) ? 125 : 600);
        end

        // Player drop and return.
        rx = '{10, 20, 30, 40}; ry = '{1, 2, 3, 4};
        run_frame("drop_a", 3, rx, ry);
        ex2 = mx[2]; ey2 = my[2];
        rx = '{900, 900, 900, 900}; ry = '{900, 900, 900, 900};
        run_frame("drop_b", 1, rx, ry);
        check("drop_hold_x2", int'(x_out[2]), ex2);
        check("drop_hold_y2", int'(y_out[2]), ey2);
        rx = '{900, 900, 1500, 1700}; ry = '{900, 900, 700, 800};
        run_frame("drop_c", 3, rx, ry);
        check("drop_raw_x3", int'(x_out[3]), 1700);
        check("drop_raw_y2", int'(y_out[2]), 700);

        // Mid-frame reset aborts without a valid_out pulse.
        @(negedge clk_in);
        num_players = 2'd3;
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        check("mrst_busy", int'(busy_out), 0);
        check_outputs("mrst");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_in);
            check("mrst_novld", int'(valid_out), 0);
        end
        rx = '{1000, 0, 0, 0}; ry = '{500, 0, 0, 0};
        run_frame("mrst_init", 0, rx, ry);

        // Reset coincident with valid_in wins.
        @(negedge clk_in);
        rst_in = 1'b1;
        valid_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        valid_in = 1'b0;
        model_reset();
        @(negedge clk_in);
        check("rstv_busy", int'(busy_out), 0);
        check_outputs("rstv");

        // Random frames: mix of small moves and arbitrary jumps.
        for (int f = 0; f < 80; f++) begin
            int n;
            n = int'($urandom_range(0, 3));
            for (int p = 0; p < 4; p++) begin
                if ($urandom_range(0, 1) == 1 && minit[p]) begin
                    rx[p] = mx[p] + int'($urandom_range(0, 120)) - 60;
                    ry[p] = my[p] + int'($urandom_range(0, 120)) - 60;
                    if (rx[p] < 0) rx[p] = 0;
                    if (rx[p] > 2047) rx[p] = 2047;
                    if (ry[p] < 0) ry[p] = 0;
                    if (ry[p] > 1023) ry[p] = 1023;
                end else begin
                    rx[p] = int'($urandom_range(0, 2047));
                    ry[p] = int'($urandom_range(0, 1023));
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk_in);
            run_frame($sformatf("rnd%0d", f), n, rx, ry);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/centroid_smoother.md
CENTROID_SMOOTHER -- requirements
Module: centroid_smoother

Interface
REQ-001 SHALL have parameter ALPHA_SHIFT, default 2: EMA weight 2^-ALPHA_SHIFT, legal range 0..4.
REQ-002 SHALL have parameter MAX_JUMP, default 200: Manhattan jump threshold in pixels, 11 bits.
REQ-003 SHALL have parameter REJECT_LIMIT, default 3: consecutive over-threshold samples before a snap, legal range 1..7.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port x_in, input, 11 bits x [3:0]: raw centroid x per player, from the clustering stage.
REQ-007 SHALL have port y_in, input, 10 bits x [3:0]: raw centroid y per player.
REQ-008 SHALL have port valid_in, input, 1 bit: one-cycle pulse marking a new frame's centroid set.
REQ-009 SHALL have port num_players, input, 2 bits: player count minus 1.
REQ-010 SHALL have port x_out, output, 11 bits x [3:0]: smoothed x per player.
REQ-011 SHALL have port y_out, output, 10 bits x [3:0]: smoothed y per player.
REQ-012 SHALL have port valid_out, output, 1 bit: one-cycle pulse when all active players have been updated.
REQ-013 SHALL have port busy_out, output, 1 bit: high while a frame is in progress.

Function
REQ-014 SHALL implement the FSM states IDLE, UPDATE and DONE.
REQ-015 In IDLE, valid_in high SHALL snapshot x_in, y_in and num_players, set player index to 0, and enter UPDATE.
REQ-016 UPDATE SHALL process exactly one player per cycle, indices 0..N with N the latched num_players, through a single shared arithmetic step; after N it SHALL enter DONE.
REQ-017 DONE SHALL assert valid_out for one cycle and return to IDLE; valid_out SHALL be high in cycle t+N+2 when valid_in is sampled in cycle t.
REQ-018 busy_out SHALL be high in UPDATE and DONE; valid_in while busy SHALL be dropped with no state change.
REQ-019 For an uninitialized player (init flag 0), the update SHALL load the raw input directly and set the init flag.
REQ-020 For an initialized player: out <= out + ((in - out) >>> ALPHA_SHIFT), using a 12-bit signed difference and arithmetic (floor) shift.
REQ-021 The EMA result SHALL stay in the inclusive range between old and in, so no clamping is needed.
REQ-022 Players with index > N SHALL keep their x_out/y_out unchanged and have their init flag and reject counter cleared in that frame.
REQ-023 x_out, y_out and valid_out SHALL be registered outputs.

Reset
REQ-024 rst_in SHALL set all x_out/y_out to 0, valid_out and busy_out to 0, all init flags and reject counters to 0, and the FSM to IDLE.
REQ-025 Reset during UPDATE or DONE SHALL abort the frame with no valid_out pulse.
REQ-026 rst_in coincident with valid_in SHALL take priority, and the frame SHALL be discarded.

Configuration
REQ-027 With CENTROID_SMOOTHER_JUMP_REJECT_EN defined, an initialized player with |dx|+|dy| > MAX_JUMP SHALL hold its output and increment its reject counter.
REQ-028 Under the same macro, the REJECT_LIMIT-th consecutive rejected sample SHALL instead load the raw input and clear the counter; any in-range sample SHALL clear the counter.
REQ-029 Without CENTROID_SMOOTHER_JUMP_REJECT_EN, SHALL have no reject counters or distance logic, and every initialized update SHALL be the pure EMA; MAX_JUMP and REJECT_LIMIT are then ignored.

Structure
REQ-030 Player-count constants (ONE_PLAYER..FOUR_PLAYERS), coordinate widths (11/10) and the FSM state enum SHALL live in the shared package kmeans_pkg.
REQ-031 The per-player combinational step (EMA plus jump test) SHALL be the sub-module ema_step, instantiated once.

Verification
REQ-032 Init load: reset, N=0, x0=100, y0=50 -> valid_out at t+2, x_out[0]=100, y_out[0]=50.
REQ-033 EMA steps: then x0=200 -> 125; then x0=100 -> 118 (floor of -25/4 is -7).
REQ-034 Latency and blocking: N=3, valid_in at t and again at t+2 -> one valid_out at t+5, busy_out high t+1..t+5, second pulse ignored.
REQ-035 Jump reject (macro on): state (125,50), input (600,50) three frames -> outputs (125,50), (125,50), then (600,50).
REQ-036 Player drop: N=3 then N=1 -> x_out/y_out[2..3] hold their values; N back to 3 -> players 2..3 load raw inputs directly.
REQ-037 Mid-frame reset: rst_in at t+2 with N=3 -> no valid_out, all outputs 0, next frame takes the init-load path.
